// File: rtl/delay_arbiter.sv
// delay_arbiter
//   Shares one 2 ms delay generator among NUM_REQ requesters. Requesters are
//   served one at a time in round-robin order. The arbiter enables the
//   generator, counts its done pulses and returns a one-cycle completion
//   pulse to the requester it served.
//
//   Parameters:
//     NUM_REQ  number of requesters (2..8)
//     TICK_W   width of each requested tick count
//
//   Ports:
//     clock      system clock
//     reset      synchronous, active-high reset
//     req        level request, one bit per requester
//     reqTicks   tick count of requester i at [i*TICK_W +: TICK_W], sampled at grant
//     grant      one-hot, high while requester i is served
//     done       one-cycle completion pulse to the served requester
//     busy       high while a service is running or completing
//     delayEn    enable to the delay generator
//     delayDone  tick pulse from the delay generator
//
//   Optional feature (macro DELAY_ARBITER_ABORT_EN): when defined, a served
//   requester that drops its req while running aborts the service without a
//   done pulse. When undefined, req is ignored after grant.
//
//   All outputs are flops decoded from the state held during the previous
//   cycle, so they trail the state register by one clock.
module delay_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TICK_W  = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*TICK_W-1:0] reqTicks,
  output logic [NUM_REQ-1:0]        grant,
  output logic [NUM_REQ-1:0]        done,
  output logic                      busy,
  output logic                      delayEn,
  input  logic                      delayDone
);

  localparam int IDX_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    win_q, win_d;
  logic [IDX_W-1:0]    last_win_q, last_win_d;
  logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [NUM_REQ-1:0]  done_q, done_d;
  logic                busy_q, busy_d;
  logic                delay_en_q, delay_en_d;

  logic [IDX_W-1:0]    pick;
  logic [TICK_W-1:0]   pick_ticks;

  // Round-robin winner: offsets are scanned from the farthest back to the
  // nearest so the closest requester above lastWin is the last one written.
  always_comb begin
    pick = last_win_q;
    for (int off = NUM_REQ; off >= 1; off--) begin
      if (req[(int'(last_win_q) + off) % NUM_REQ]) begin
        pick = IDX_W'((int'(last_win_q) + off) % NUM_REQ);
      end
    end
    pick_ticks = reqTicks[int'(pick)*TICK_W +: TICK_W];
  end

  // Next-state logic.
  always_comb begin
    state_d    = state_q;
    win_d      = win_q;
    last_win_d = last_win_q;
    tick_cnt_d = tick_cnt_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          win_d      = pick;
          last_win_d = pick;
          tick_cnt_d = pick_ticks;
          state_d    = (pick_ticks == '0) ? DONE : RUN;
        end
      end
      RUN: begin
`ifdef DELAY_ARBITER_ABORT_EN
        // A final tick landing in the same cycle as the drop still completes.
        if (delayDone && tick_cnt_q == TICK_W'(1)) begin
          tick_cnt_d = tick_cnt_q - 1'b1;
          state_d    = DONE;
        end else if (!req[win_q]) begin
          state_d = IDLE;
        end else if (delayDone) begin
          tick_cnt_d = tick_cnt_q - 1'b1;
        end
`else
        if (delayDone) begin
          tick_cnt_d = tick_cnt_q - 1'b1;
          if (tick_cnt_q == TICK_W'(1)) begin
            state_d = DONE;
          end
        end
`endif
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output decode from the current state; registered below.
  always_comb begin
    grant_d    = '0;
    done_d     = '0;
    busy_d     = 1'b0;
    delay_en_d = 1'b0;
    case (state_q)
      RUN: begin
        grant_d[win_q] = 1'b1;
        busy_d         = 1'b1;
        delay_en_d     = 1'b1;
      end
      DONE: begin
        done_d[win_q] = 1'b1;
        busy_d        = 1'b1;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      win_q      <= '0;
      last_win_q <= IDX_W'(NUM_REQ - 1);
      tick_cnt_q <= '0;
      grant_q    <= '0;
      done_q     <= '0;
      busy_q     <= 1'b0;
      delay_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      win_q      <= win_d;
      last_win_q <= last_win_d;
      tick_cnt_q <= tick_cnt_d;
      grant_q    <= grant_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      delay_en_q <= delay_en_d;
    end
  end

  assign grant   = grant_q;
  assign done    = done_q;
  assign busy    = busy_q;
  assign delayEn = delay_en_q;

endmodule
